// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data-memory responder.
//   dmem_state_t : CLEAR -> LOAD -> RUN sequencing of the responder.
//   WORD_W       : data word width in bits.
//   dmem_map_t   : result of mapping a CPU byte address onto the word array.
//   map_addr()   : word index and in-range test for a CPU byte address.
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [31:0] idx;       // word index relative to the base address
    logic        in_range;  // address lands inside the array
  } dmem_map_t;

  // The offset is taken modulo 2^32, so an address below the base wraps to a
  // huge offset and fails the unsigned compare: no separate lower-bound test.
  function automatic dmem_map_t map_addr(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth_words);
    logic [31:0] offset;
    dmem_map_t   m;
    offset     = addr - base;
    m.idx      = offset >> 2;
    m.in_range = offset < (32'(depth_words) << 2);
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH_WORDS x WORD_W storage with one synchronous write port and one
// asynchronous (combinational) read port.
// Ports:
//   clk    : write clock
//   we     : write enable, sampled on the rising edge
//   waddr  : write word index
//   wdata  : write data
//   raddr  : read word index
//   rdata  : read data, combinational from raddr; shows the pre-write word
//            during a same-address write cycle
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // NOTE: the storage has no reset term; resetting every word would turn the
  // array into flops. The owner clears it explicitly by sweeping addresses.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the single-cycle core's D-port. After reset the
// word array is zeroed (CLEAR), then preloaded from a valid/ready stream
// (LOAD), then serves CPU reads combinationally and CPU writes on the clock
// edge (RUN). Out-of-range and misaligned CPU writes are dropped and raise
// sticky error flags.
//
// Optional build macro: DMEM_STATS_EN adds saturating write/drop counters.
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   mem_wen_D      : CPU write enable
//   mem_addr_D     : CPU byte address
//   mem_wdata_D    : CPU write data (stored verbatim)
//   mem_rdata_D    : CPU read data (0 while busy or out of range)
//   ld_valid       : load word valid
//   ld_ready       : load word accepted (high throughout LOAD)
//   ld_data        : load word
//   ld_last        : final load word
//   busy           : high in CLEAR and LOAD; CPU port inactive
//   err_range      : sticky, a CPU write fell outside the array
//   err_misalign   : sticky, a CPU write had a nonzero byte offset
//   wr_count       : accepted CPU writes (DMEM_STATS_EN only)
//   drop_count     : suppressed CPU writes (DMEM_STATS_EN only)
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_wen_D,
  input  logic [31:0] mem_addr_D,
  input  logic [31:0] mem_wdata_D,
  output logic [31:0] mem_rdata_D,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        busy,
  output logic        err_range,
  output logic        err_misalign
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] wr_count,
  output logic [31:0] drop_count
`endif
);

  localparam int            AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  dmem_state_t state_q, state_d;
  logic [AW-1:0] clr_ptr_q;
  logic [AW-1:0] ld_ptr_q;

  // Array write port, shared by the clear sweep, the load stream and the CPU.
  logic              arr_we;
  logic [AW-1:0]     arr_waddr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;

  // CPU address decode.
  dmem_map_t cpu_map;
  logic      cpu_aligned;
  logic      cpu_wr_ok;
  logic      cpu_wr_drop;
  logic      unused_idx_hi;

  assign cpu_map     = map_addr(mem_addr_D, BASE_ADDR, DEPTH_WORDS);
  assign cpu_aligned = (mem_addr_D[1:0] == 2'b00);
  // Upper index bits are zero whenever in_range holds, so only the low AW
  // bits address the array.
  assign unused_idx_hi = ^cpu_map.idx[31:AW];

  // ---------------------------------------------------------------------------
  // Next state, write-port mux and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    arr_we      = 1'b0;
    arr_waddr   = clr_ptr_q;
    arr_wdata   = '0;
    ld_ready    = 1'b0;
    busy        = 1'b1;
    cpu_wr_ok   = 1'b0;
    cpu_wr_drop = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = clr_ptr_q;
        if (clr_ptr_q == LAST_IDX) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          arr_we    = 1'b1;
          arr_waddr = ld_ptr_q;
          arr_wdata = ld_data;
          // A full array ends the load even without ld_last, so the
          // pointer never has to wrap.
          if (ld_last || (ld_ptr_q == LAST_IDX)) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        busy = 1'b0;
        if (mem_wen_D) begin
          if (cpu_map.in_range && cpu_aligned) begin
            arr_we    = 1'b1;
            arr_waddr = cpu_map.idx[AW-1:0];
            arr_wdata = mem_wdata_D;
            cpu_wr_ok = 1'b1;
          end else begin
            cpu_wr_drop = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, pointers and sticky flags
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled on the clock edge (synchronous), so rst_n is not
  // in the sensitivity list; all state updates use non-blocking assignment so
  // every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      ld_ptr_q     <= '0;
      err_range    <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_CLEAR) begin
        clr_ptr_q <= clr_ptr_q + 1'b1;
      end

      if ((state_q == ST_CLEAR) && (state_d == ST_LOAD)) begin
        ld_ptr_q <= '0;
      end else if ((state_q == ST_LOAD) && ld_valid && (state_d == ST_LOAD)) begin
        ld_ptr_q <= ld_ptr_q + 1'b1;
      end

      // Only write cycles are checked; the core drives the address on every
      // instruction, so a stray read address is not an error.
      if (cpu_wr_drop && !cpu_map.in_range) begin
        err_range <= 1'b1;
      end
      if (cpu_wr_drop && !cpu_aligned) begin
        err_misalign <= 1'b1;
      end
    end
  end

`ifdef DMEM_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating traffic counters (RUN only, via cpu_wr_ok / cpu_wr_drop)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      if (cpu_wr_ok && (wr_count != 32'hFFFF_FFFF)) begin
        wr_count <= wr_count + 32'd1;
      end
      if (cpu_wr_drop && (drop_count != 32'hFFFF_FFFF)) begin
        drop_count <= drop_count + 32'd1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Storage and read path
  // ---------------------------------------------------------------------------
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (cpu_map.idx[AW-1:0]),
    .rdata (arr_rdata)
  );

  assign mem_rdata_D = ((state_q == ST_RUN) && cpu_map.in_range) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder (DEPTH_WORDS=256, BASE_ADDR=0).
// A behavioural model (word array, clear countdown, load/run flags, sticky
// flags) tracks what the outputs must be; a compare process checks the DUT
// against it on every falling edge, and directed steps pin the model with
// hand-computed literals. Build with DMEM_STATS_EN to cover the counters.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        mem_wen_D;
  logic [31:0] mem_addr_D;
  logic [31:0] mem_wdata_D;
  logic [31:0] mem_rdata_D;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        busy;
  logic        err_range;
  logic        err_misalign;
`ifdef DMEM_STATS_EN
  logic [31:0] wr_count;
  logic [31:0] drop_count;
`endif

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_wen_D    (mem_wen_D),
    .mem_addr_D   (mem_addr_D),
    .mem_wdata_D  (mem_wdata_D),
    .mem_rdata_D  (mem_rdata_D),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .busy         (busy),
    .err_range    (err_range),
    .err_misalign (err_misalign)
`ifdef DMEM_STATS_EN
    ,
    .wr_count     (wr_count),
    .drop_count   (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem [DEPTH];
  bit          m_valid = 1'b0;
  int          m_clear_left;   // words still to be zeroed
  bit          m_loading;
  bit          m_run;
  int          m_ld_next;      // next word the load stream fills
  bit          m_err_r;
  bit          m_err_m;
  logic [31:0] m_wr;
  logic [31:0] m_drop;

  logic [31:0] m_off;
  bit          m_in;
  bit          m_misal;
  assign m_off   = mem_addr_D - BASE;
  assign m_in    = (m_off < 32'(4 * DEPTH));
  assign m_misal = (mem_addr_D[1:0] != 2'b00);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid      <= 1'b1;
      m_clear_left <= DEPTH;
      m_loading    <= 1'b0;
      m_run        <= 1'b0;
      m_ld_next    <= 0;
      m_err_r      <= 1'b0;
      m_err_m      <= 1'b0;
      m_wr         <= '0;
      m_drop       <= '0;
    end else if (m_valid) begin
      if (m_clear_left > 0) begin
        m_mem[DEPTH - m_clear_left] <= '0;
        m_clear_left <= m_clear_left - 1;
        if (m_clear_left == 1) begin
          m_loading <= 1'b1;
          m_ld_next <= 0;
        end
      end else if (m_loading) begin
        if (ld_valid) begin
          m_mem[m_ld_next] <= ld_data;
          m_ld_next <= m_ld_next + 1;
          if (ld_last || (m_ld_next == DEPTH - 1)) begin
            m_loading <= 1'b0;
            m_run     <= 1'b1;
          end
        end
      end else if (m_run && mem_wen_D) begin
        if (m_in && !m_misal) begin
          m_mem[int'(m_off >> 2)] <= mem_wdata_D;
          if (m_wr != 32'hFFFF_FFFF) m_wr <= m_wr + 1;
        end else begin
          if (!m_in) m_err_r <= 1'b1;
          if (m_misal) m_err_m <= 1'b1;
          if (m_drop != 32'hFFFF_FFFF) m_drop <= m_drop + 1;
        end
      end
    end
  end

  // Compare process: outputs checked mid-cycle against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {31'b0, busy}, {31'b0, !m_run});
      check("ld_ready", {31'b0, ld_ready}, {31'b0, m_loading});
      check("err_range", {31'b0, err_range}, {31'b0, m_err_r});
      check("err_misalign", {31'b0, err_misalign}, {31'b0, m_err_m});
      check("rdata", mem_rdata_D, (m_run && m_in) ? m_mem[int'(m_off >> 2)] : 32'h0);
`ifdef DMEM_STATS_EN
      check("wr_count", wr_count, m_wr);
      check("drop_count", drop_count, m_drop);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    mem_wen_D = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ld_ready && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic load_word(input logic [31:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    mem_wen_D   = 1'b1;
    mem_addr_D  = addr;
    mem_wdata_D = data;
    tick();
    mem_wen_D = 1'b0;
  endtask

  task automatic random_round(input bit use_last, input int len);
    int beats;
    int guard;
    int r;
    int n;
    do_reset(1);
    wait_ready(n);
    check("rnd_ready_latency", n, DEPTH);
    beats = 0;
    guard = 0;
    while (busy && guard < 3000) begin
      ld_valid    = ($urandom_range(0, 9) < 7);
      ld_data     = $urandom;
      ld_last     = ld_valid && use_last && (beats == len - 1);
      mem_wen_D   = $urandom_range(0, 1);
      mem_addr_D  = $urandom_range(0, 63) << 2;
      mem_wdata_D = $urandom;
      tick();
      if (ld_valid) beats++;
      guard++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("rnd_load_done", {31'b0, busy}, 32'h0);
    check("rnd_load_beats", beats, use_last ? len : DEPTH);
    repeat (500) begin
      mem_wen_D   = $urandom_range(0, 1);
      mem_wdata_D = $urandom;
      ld_valid    = $urandom_range(0, 1);
      ld_data     = $urandom;
      r = $urandom_range(0, 99);
      if (r < 45)      mem_addr_D = BASE + ($urandom_range(0, 15) << 2);
      else if (r < 60) mem_addr_D = BASE + ($urandom_range(0, DEPTH - 1) << 2);
      else if (r < 75) mem_addr_D = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(1, 3);
      else if (r < 90) mem_addr_D = BASE + 4 * DEPTH + $urandom_range(0, 255);
      else             mem_addr_D = $urandom;
      tick();
    end
    mem_wen_D = 1'b0;
    ld_valid  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    rst_n       = 1'b0;
    mem_wen_D   = 1'b0;
    mem_addr_D  = '0;
    mem_wdata_D = '0;
    ld_valid    = 1'b0;
    ld_data     = '0;
    ld_last     = 1'b0;

    // Reset values.
    do_reset(2);
    check("rst_busy", {31'b0, busy}, 32'h1);
    check("rst_ld_ready", {31'b0, ld_ready}, 32'h0);
    check("rst_rdata", mem_rdata_D, 32'h0);
    check("rst_err_range", {31'b0, err_range}, 32'h0);
    check("rst_err_misalign", {31'b0, err_misalign}, 32'h0);

    // CLEAR takes DEPTH cycles; a lone ld_last beat of zero ends LOAD.
    wait_ready(n);
    check("ready_latency", n, 256);
    load_word(32'h0, 1'b1);
    check("single_beat_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      mem_addr_D = BASE + 32'(i * 4);
      #1;
      check("cleared_word", mem_rdata_D, 32'h0);
    end
    tick();

    // Three-word preload.
    do_reset(1);
    wait_ready(n);
    check("ready_latency2", n, 256);
    load_word(32'h1122_3344, 1'b0);
    load_word(32'hAABB_CCDD, 1'b0);
    check("busy_mid_load", {31'b0, busy}, 32'h1);
    load_word(32'h0000_0000, 1'b1);
    check("busy_after_last", {31'b0, busy}, 32'h0);
    mem_addr_D = 32'h0; #1;
    check("load_w0", mem_rdata_D, 32'h1122_3344);
    mem_addr_D = 32'h4; #1;
    check("load_w1", mem_rdata_D, 32'hAABB_CCDD);
    mem_addr_D = 32'h8; #1;
    check("load_w2", mem_rdata_D, 32'h0);
    tick();

    // Same-cycle read shows the old word; new word visible next cycle.
    mem_wen_D   = 1'b1;
    mem_addr_D  = 32'h10;
    mem_wdata_D = 32'hDEAD_BEEF;
    #1;
    check("rw_same_cycle_old", mem_rdata_D, 32'h0);
    tick();
    mem_wen_D = 1'b0;
    #1;
    check("rw_next_cycle_new", mem_rdata_D, 32'hDEAD_BEEF);

    // Reads out of range never flag.
    mem_addr_D = 32'h400;
    repeat (10) tick();
    check("read_oor_no_err", {31'b0, err_range}, 32'h0);
    check("read_oor_rdata", mem_rdata_D, 32'h0);

    // Out-of-range write, then misaligned write.
    cpu_write(32'h400, 32'h5555_AAAA);
    check("wr_oor_err_range", {31'b0, err_range}, 32'h1);
    check("wr_oor_err_misalign", {31'b0, err_misalign}, 32'h0);
    mem_addr_D = 32'h0; #1;
    check("wr_oor_w0_intact", mem_rdata_D, 32'h1122_3344);
    cpu_write(32'h13, 32'h0BAD_F00D);
    check("wr_misal_err", {31'b0, err_misalign}, 32'h1);
    mem_addr_D = 32'h13; #1;
    check("wr_misal_w4_intact", mem_rdata_D, 32'hDEAD_BEEF);
    tick();

    // Reset mid-LOAD.
    do_reset(1);
    check("rst2_flags", {30'b0, err_range, err_misalign}, 32'h0);
    wait_ready(n);
    load_word(32'h1234_5678, 1'b0);
    load_word(32'h9ABC_DEF0, 1'b0);
    check("midload_ready", {31'b0, ld_ready}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midload_rst_ready", {31'b0, ld_ready}, 32'h0);
    check("midload_rst_busy", {31'b0, busy}, 32'h1);
    wait_ready(n);
    check("midload_ready_latency", n, 256);
    load_word(32'hCAFE_0001, 1'b1);
    mem_addr_D = 32'h0; #1;
    check("midload_w0", mem_rdata_D, 32'hCAFE_0001);
    mem_addr_D = 32'h4; #1;
    check("midload_w1_cleared", mem_rdata_D, 32'h0);

`ifdef DMEM_STATS_EN
    check("stats_rst_wr", wr_count, 32'd0);
    check("stats_rst_drop", drop_count, 32'd0);
    cpu_write(32'h20, 32'h1);
    cpu_write(32'h24, 32'h2);
    cpu_write(32'h26, 32'h3);
    check("stats_wr", wr_count, 32'd2);
    check("stats_drop", drop_count, 32'd1);
`endif
    tick();

    // Randomized rounds: short loads with ld_last, and one full-depth load.
    random_round(1'b1, 5);
    random_round(1'b1, $urandom_range(1, 40));
    random_round(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle RISC-V core's D-port: it answers `mem_wen_D` / `mem_addr_D` / `mem_wdata_D` with `mem_rdata_D` exactly as the core expects (combinational read, write on the clock edge). Behind the port it holds a word array that is zero-cleared after reset and then preloaded through a valid/ready load stream before CPU traffic is served. Address-range and alignment checking, plus sticky error flags, make it usable as both the simulation memory and the synthesizable scratchpad.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words; power of two, at least 4.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; word-aligned.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `mem_wen_D` in 1: CPU write enable.
- `mem_addr_D` in 32: CPU byte address.
- `mem_wdata_D` in 32: CPU write data, in bus byte order; stored verbatim.
- `mem_rdata_D` out 32: read data, in bus byte order.
- `ld_valid` in 1: load word valid.
- `ld_ready` out 1: load word accepted when `ld_valid` & `ld_ready`.
- `ld_data` in 32: load word, in bus byte order.
- `ld_last` in 1: marks the final load word.
- `busy` out 1: high while in CLEAR or LOAD; the CPU port is inactive.
- `err_range` out 1: sticky flag; a CPU write fell outside the array.
- `err_misalign` out 1: sticky flag; a CPU write had `mem_addr_D[1:0]` ≠ 0.
- `wr_count` out 32: accepted CPU writes. Present only with the macro.
- `drop_count` out 32: suppressed CPU writes. Present only with the macro.

## Operation
- FSM states: CLEAR → LOAD → RUN. A synchronous reset from any state returns to CLEAR.
- **CLEAR**
  - Writes 0 to word `clr_ptr`, then increments it, one word per cycle.
  - After writing word `DEPTH_WORDS-1`, moves to LOAD and resets the load pointer to 0.
- **LOAD**
  - `ld_ready` is 1.
  - Each handshake writes `ld_data` to word `ld_ptr` and increments `ld_ptr`.
  - Moves to RUN on a handshake with `ld_last`=1, or on the handshake that writes word `DEPTH_WORDS-1`.
  - Moves to RUN immediately if `ld_valid`=1 with `ld_last`=1 on the first beat.
  - The pointer never wraps.
- **RUN**
  - Word index `idx = (mem_addr_D - BASE_ADDR) >> 2`, computed in 32 bits.
  - `in_range = (mem_addr_D - BASE_ADDR) < 4*DEPTH_WORDS`, unsigned compare, so addresses below `BASE_ADDR` are out of range.
  - Read:
    - `mem_rdata_D = array[idx]` combinationally when `in_range`, else 0.
    - `mem_addr_D[1:0]` is ignored for reads.
  - Write:
    - Committed at posedge when `mem_wen_D` & `in_range` & `mem_addr_D[1:0]`==0.
    - Otherwise suppressed: set `err_range` if not `in_range`, and set `err_misalign` if misaligned; both can set together.
  - Read traffic never sets error flags. The core drives `mem_addr_D` from its ALU on every instruction and has no read strobe.
- `mem_rdata_D` is 0 whenever `busy`=1. `mem_wen_D` is ignored when `busy`=1: no error, no count.
- Same-address read and write in one cycle: `mem_rdata_D` shows the old word; the new word is visible from the next cycle.
- Byte order: the block performs no swapping. Words are stored and returned exactly as carried on the bus.

## Timing
- Reset values:
  - State CLEAR, `clr_ptr`=0, `ld_ptr`=0.
  - `busy`=1, `ld_ready`=0.
  - `err_range`=0, `err_misalign`=0.
  - Counters 0.
  - `mem_rdata_D`=0.
- Array contents are not reset directly. CLEAR zeroes them in `DEPTH_WORDS` cycles.
- `ld_ready` rises the cycle after the last CLEAR write, which is `DEPTH_WORDS` cycles after reset deassertion.
- `busy` falls in the cycle after the terminating load handshake.
- Read latency is 0 cycles (combinational). Writes are visible 1 cycle after commit.
- Error flags rise the cycle after the offending write cycle and hold until reset.

## Configuration
- `DMEM_STATS_EN` defined:
  - `wr_count` and `drop_count` exist as 32-bit saturating counters (hold at 32'hFFFF_FFFF), updated in RUN only.
  - `drop_count` increments once per suppressed write cycle.
- `DMEM_STATS_EN` undefined: both ports and all counter logic are absent. All other behaviour is identical.

## Structure
- Package `dmem_pkg`:
  - State enum `dmem_state_t` (CLEAR, LOAD, RUN).
  - Word width constant 32.
  - Helper function for index/in-range computation.
- Sub-module `dmem_array`: `DEPTH_WORDS`×32 storage, one synchronous write port, one asynchronous read port.
- The top level contains the FSM, pointers, the write-source mux (clear / load / CPU), checks, flags and counters.

## Test plan
- Reset, then idle load stream: `busy`=1 for 256 cycles; `ld_ready` rises at cycle 256; every word reads 0 once a single `ld_last` beat ends LOAD.
- Load 3 words 32'h11223344, 32'hAABBCCDD, 32'h0, with `ld_last` on the third: `busy` falls the next cycle; reads of addresses 0/4/8 return those words verbatim.
- RUN write 32'hDEADBEEF to address 0x10, read same cycle → old value; next cycle → 32'hDEADBEEF.
- Write to 0x400 (DEPTH 256) → no array change, `err_range`=1, `mem_rdata_D`=0 for that address. Write to 0x13 → `err_misalign`=1, word 4 unchanged.
- Read 0x400 repeatedly with `mem_wen_D`=0 → `err_range` stays 0.
- Assert `rst_n`=0 for one cycle mid-LOAD: returns to CLEAR, flags and counters zero, `ld_ready`=0. With `DMEM_STATS_EN`: 2 good and 1 bad write give `wr_count`=2, `drop_count`=1.
